// File: rtl/msix_msg_gen.sv
// MSI-X message generator: pending bit array, per-vector/function masking, round-robin dword write issue.
// Optional build macro MSIX_MSG_CNT_EN adds msg_cnt / coalesce_cnt statistics outputs.
module msix_msg_gen #(
    parameter int NUM_VEC = 8,
    parameter int VEC_W   = $clog2(NUM_VEC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_VEC-1:0] intr_req,
    input  logic               msix_en,
    input  logic               func_mask,
    input  logic               cfg_wr,
    input  logic [VEC_W-1:0]   cfg_vec,
    input  logic [63:0]        cfg_addr,
    input  logic [31:0]        cfg_data,
    input  logic               cfg_mask,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [63:0]        wr_addr,
    output logic [31:0]        wr_data,
    output logic [NUM_VEC-1:0] pba,
    output logic               busy
`ifdef MSIX_MSG_CNT_EN
    ,
    output logic [15:0]        msg_cnt,
    output logic [15:0]        coalesce_cnt
`endif
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q;
    logic [63:0]        tbl_addr_q [NUM_VEC];
    logic [31:0]        tbl_data_q [NUM_VEC];
    logic [NUM_VEC-1:0] tbl_mask_q;
    logic [NUM_VEC-1:0] pba_q, pba_d;
    logic [VEC_W-1:0]   rr_ptr_q, cur_vec_q;
    logic               wr_valid_q;
    logic [63:0]        wr_addr_q;
    logic [31:0]        wr_data_q;

    logic [NUM_VEC-1:0] eligible;
    logic [NUM_VEC-1:0] clr_vec;
    logic               hs;
    logic               pick_vld;
    logic [VEC_W-1:0]   pick_idx;
    logic               cfg_hit;

    assign eligible = pba_q & ~tbl_mask_q & {NUM_VEC{msix_en & ~func_mask}};
    assign hs       = (state_q == SEND) & wr_valid_q & wr_ready;
    assign clr_vec  = hs ? ({{(NUM_VEC-1){1'b0}}, 1'b1} << cur_vec_q) : '0;
    // A strobe landing on the handshake cycle re-arms the vector: set wins over clear.
    assign pba_d    = (pba_q & ~clr_vec) | intr_req;
    assign cfg_hit  = cfg_wr & ({1'b0, cfg_vec} < (VEC_W+1)'(NUM_VEC));

    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int k = 0; k < NUM_VEC; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_VEC) idx = idx - NUM_VEC;
            if (!pick_vld && eligible[idx]) begin
                pick_vld = 1'b1;
                pick_idx = VEC_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pba_q      <= '0;
            rr_ptr_q   <= '0;
            cur_vec_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            tbl_mask_q <= '1;
            for (int i = 0; i < NUM_VEC; i++) begin
                tbl_addr_q[i] <= '0;
                tbl_data_q[i] <= '0;
            end
        end else begin
            pba_q <= pba_d;
            if (cfg_hit) begin
                tbl_addr_q[cfg_vec] <= cfg_addr;
                tbl_data_q[cfg_vec] <= cfg_data;
                tbl_mask_q[cfg_vec] <= cfg_mask;
            end
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q    <= SEND;
                        wr_valid_q <= 1'b1;
                        wr_addr_q  <= tbl_addr_q[pick_idx];
                        wr_data_q  <= tbl_data_q[pick_idx];
                        cur_vec_q  <= pick_idx;
                    end
                end
                SEND: begin
                    // Message is committed: masks and table writes no longer affect it.
                    if (wr_ready) begin
                        state_q    <= IDLE;
                        wr_valid_q <= 1'b0;
                        rr_ptr_q   <= (cur_vec_q == VEC_W'(NUM_VEC-1)) ? '0 : cur_vec_q + VEC_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign pba      = pba_q;
    assign busy     = (state_q == SEND);

`ifdef MSIX_MSG_CNT_EN
    logic [15:0] msg_cnt_q, coal_cnt_q, coal_inc;

    always_comb begin
        coal_inc = '0;
        for (int i = 0; i < NUM_VEC; i++) begin
            if (intr_req[i] & pba_q[i] & ~clr_vec[i]) coal_inc = coal_inc + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msg_cnt_q  <= '0;
            coal_cnt_q <= '0;
        end else begin
            if (hs) msg_cnt_q <= msg_cnt_q + 16'd1;
            coal_cnt_q <= coal_cnt_q + coal_inc;
        end
    end

    assign msg_cnt      = msg_cnt_q;
    assign coalesce_cnt = coal_cnt_q;
`endif

endmodule

// File: tb/tb_msix_msg_gen.sv
// Directed self-checking bench for msix_msg_gen (NUM_VEC=8).
module tb_msix_msg_gen;
    localparam int NUM_VEC = 8;
    localparam int VEC_W   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_VEC-1:0] intr_req;
    logic               msix_en, func_mask, cfg_wr, cfg_mask, wr_ready;
    logic [VEC_W-1:0]   cfg_vec;
    logic [63:0]        cfg_addr;
    logic [31:0]        cfg_data;
    logic               wr_valid, busy;
    logic [63:0]        wr_addr;
    logic [31:0]        wr_data;
    logic [NUM_VEC-1:0] pba;
`ifdef MSIX_MSG_CNT_EN
    logic [15:0]        msg_cnt, coalesce_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] seen_q[$];

    msix_msg_gen #(.NUM_VEC(NUM_VEC)) dut (
        .clk(clk), .rst(rst), .intr_req(intr_req), .msix_en(msix_en),
        .func_mask(func_mask), .cfg_wr(cfg_wr), .cfg_vec(cfg_vec),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_mask(cfg_mask),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .pba(pba), .busy(busy)
`ifdef MSIX_MSG_CNT_EN
        , .msg_cnt(msg_cnt), .coalesce_cnt(coalesce_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; intr_req = '0; msix_en = 1'b0; func_mask = 1'b0;
        cfg_wr = 1'b0; cfg_vec = '0; cfg_addr = '0; cfg_data = '0; cfg_mask = 1'b1;
        wr_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic cfg(input logic [VEC_W-1:0] v, input logic [63:0] a,
                       input logic [31:0] d, input logic m);
        cfg_wr = 1'b1; cfg_vec = v; cfg_addr = a; cfg_data = d; cfg_mask = m;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
        checks++; if (wr_addr !== 64'h0) begin errors++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        checks++; if (pba !== 8'h00) begin errors++; $display("FAIL reset_pba: got %h want 00", pba); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        cfg(3'd3, 64'h1, 32'h12345678, 1'b0);
        msix_en = 1'b1; wr_ready = 1'b1;
        intr_req = 8'h08;
        tick();
        intr_req = 8'h00;
        checks++; if (pba !== 8'h08) begin errors++; $display("FAIL basic_pba_set: got %h want 08", pba); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", wr_valid); end
        tick();
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", wr_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        checks++; if (wr_addr !== 64'h1) begin errors++; $display("FAIL basic_addr: got %h want 1", wr_addr); end
        checks++; if (wr_data !== 32'h12345678) begin errors++; $display("FAIL basic_data: got %h want 12345678", wr_data); end
        tick();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", wr_valid); end
        checks++; if (pba !== 8'h00) begin errors++; $display("FAIL basic_pba_clr: got %h want 00", pba); end
        tick();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL basic_no_repeat: got %b want 0", wr_valid); end
    endtask

    task automatic test_backpressure();
        wr_ready = 1'b0;
        intr_req = 8'h08;
        tick();
        intr_req = 8'h00;
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                cfg_wr = 1'b1; cfg_vec = 3'd3; cfg_addr = 64'h1; cfg_data = 32'hAA; cfg_mask = 1'b0;
            end
            checks++;
            if (wr_valid !== 1'b1 || wr_addr !== 64'h1 || wr_data !== 32'h12345678) begin
                errors++;
                $display("FAIL bp_stable[%0d]: got v=%b a=%h d=%h want v=1 a=1 d=12345678", k, wr_valid, wr_addr, wr_data);
            end
            tick();
            cfg_wr = 1'b0;
        end
        checks++; if (wr_data !== 32'h12345678) begin errors++; $display("FAIL bp_stable_last: got %h want 12345678", wr_data); end
        wr_ready = 1'b1;
        tick();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", wr_valid); end
        intr_req = 8'h08;
        tick();
        intr_req = 8'h00;
        tick();
        checks++; if (wr_valid !== 1'b1 || wr_data !== 32'hAA) begin errors++; $display("FAIL bp_new_data: got v=%b d=%h want v=1 d=aa", wr_valid, wr_data); end
        tick();
    endtask

    task automatic test_mask_pba();
        int sent;
        cfg(3'd1, 64'h100, 32'h11, 1'b1);
        wr_ready = 1'b1;
        intr_req = 8'h02;
        tick();
        intr_req = 8'h00;
        sent = 0;
        for (int k = 0; k < 20; k++) begin
            if (wr_valid) sent++;
            tick();
        end
        checks++; if (sent != 0) begin errors++; $display("FAIL mask_blocks: got %0d valid cycles want 0", sent); end
        checks++; if (pba[1] !== 1'b1) begin errors++; $display("FAIL mask_pba_held: got %b want 1", pba[1]); end
        cfg(3'd1, 64'h100, 32'h11, 1'b0);
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL unmask_too_early: got %b want 0", wr_valid); end
        tick();
        checks++; if (wr_valid !== 1'b1 || wr_addr !== 64'h100) begin errors++; $display("FAIL unmask_send: got v=%b a=%h want v=1 a=100", wr_valid, wr_addr); end
        tick();
        checks++; if (pba[1] !== 1'b0) begin errors++; $display("FAIL unmask_pba_clr: got %b want 0", pba[1]); end
        // Function mask gates an otherwise eligible vector.
        func_mask = 1'b1;
        intr_req = 8'h02;
        tick();
        intr_req = 8'h00;
        sent = 0;
        for (int k = 0; k < 5; k++) begin
            if (wr_valid) sent++;
            tick();
        end
        checks++; if (sent != 0) begin errors++; $display("FAIL func_mask_blocks: got %0d valid cycles want 0", sent); end
        func_mask = 1'b0;
        tick();
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL func_unmask_send: got %b want 1", wr_valid); end
        tick();
    endtask

    task automatic collect(input int n);
        seen_q.delete();
        for (int k = 0; k < n; k++) begin
            if (wr_valid && wr_ready) seen_q.push_back(wr_data);
            tick();
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        cfg(3'd0, 64'h1000, 32'hD0, 1'b0);
        cfg(3'd2, 64'h1002, 32'hD2, 1'b0);
        cfg(3'd7, 64'h1007, 32'hD7, 1'b0);
        msix_en = 1'b1; wr_ready = 1'b1;
        intr_req = 8'h85;
        tick();
        intr_req = 8'h00;
        collect(14);
        checks++;
        if (seen_q.size() != 3) begin errors++; $display("FAIL rr_count: got %0d want 3", seen_q.size()); end
        else if (seen_q[0] !== 32'hD0 || seen_q[1] !== 32'hD2 || seen_q[2] !== 32'hD7) begin
            errors++; $display("FAIL rr_order: got %h %h %h want d0 d2 d7", seen_q[0], seen_q[1], seen_q[2]);
        end
        // Sending vec2 alone leaves the pointer at 3.
        intr_req = 8'h04;
        tick();
        intr_req = 8'h00;
        collect(6);
        checks++; if (seen_q.size() != 1) begin errors++; $display("FAIL rr_single: got %0d want 1", seen_q.size()); end
        intr_req = 8'h85;
        tick();
        intr_req = 8'h00;
        collect(14);
        checks++;
        if (seen_q.size() != 3) begin errors++; $display("FAIL rr_wrap_count: got %0d want 3", seen_q.size()); end
        else if (seen_q[0] !== 32'hD7 || seen_q[1] !== 32'hD0 || seen_q[2] !== 32'hD2) begin
            errors++; $display("FAIL rr_wrap_order: got %h %h %h want d7 d0 d2", seen_q[0], seen_q[1], seen_q[2]);
        end
    endtask

    task automatic test_coalesce();
        int hs_cnt;
        do_reset();
        cfg(3'd5, 64'h5000, 32'h55, 1'b0);
        msix_en = 1'b1; wr_ready = 1'b0;
        hs_cnt = 0;
        intr_req = 8'h20;
        for (int k = 0; k < 4; k++) tick();
        intr_req = 8'h00;
        tick();
        // Strobe again exactly on the handshake cycle.
        intr_req = 8'h20; wr_ready = 1'b1;
        if (wr_valid && wr_ready) hs_cnt++;
        tick();
        intr_req = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (wr_valid && wr_ready) hs_cnt++;
            tick();
        end
        checks++; if (hs_cnt != 2) begin errors++; $display("FAIL coalesce_msgs: got %0d want 2", hs_cnt); end
        checks++; if (pba !== 8'h00) begin errors++; $display("FAIL coalesce_pba: got %h want 00", pba); end
`ifdef MSIX_MSG_CNT_EN
        checks++; if (msg_cnt !== 16'd2) begin errors++; $display("FAIL msg_cnt: got %0d want 2", msg_cnt); end
        checks++; if (coalesce_cnt !== 16'd3) begin errors++; $display("FAIL coalesce_cnt: got %0d want 3", coalesce_cnt); end
`endif
    endtask

    task automatic test_reset_mid_send();
        int sent;
        wr_ready = 1'b0;
        intr_req = 8'h20;
        tick();
        intr_req = 8'h00;
        tick();
        checks++; if (busy !== 1'b1 || wr_valid !== 1'b1) begin errors++; $display("FAIL rms_in_send: got busy=%b v=%b want 1 1", busy, wr_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL rms_valid: got %b want 0", wr_valid); end
        checks++; if (pba !== 8'h00) begin errors++; $display("FAIL rms_pba: got %h want 00", pba); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rms_busy: got %b want 0", busy); end
        wr_ready = 1'b1;
        sent = 0;
        for (int k = 0; k < 10; k++) begin
            if (wr_valid) sent++;
            tick();
        end
        checks++; if (sent != 0) begin errors++; $display("FAIL rms_no_msg: got %0d want 0", sent); end
        // New strobe against the reset (masked) table still only pends.
        intr_req = 8'h20;
        tick();
        intr_req = 8'h00;
        sent = 0;
        for (int k = 0; k < 6; k++) begin
            if (wr_valid) sent++;
            tick();
        end
        checks++; if (sent != 0 || pba !== 8'h20) begin errors++; $display("FAIL rms_masked_after: got sent=%0d pba=%h want 0 20", sent, pba); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_mask_pba();
        test_round_robin();
        test_coalesce();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
